// File: rtl/sram16_responder.sv
// ---------------------------------------------------------------------------
// sram16_responder
//
// Memory end of the CPU's external 16-bit half-word bus. It stores
// half-words in an internal array with byte-lane write enables. Read data
// comes back through a fixed-latency pipeline. Consecutive half-word writes
// (upper half at base, lower half at base+2) are reassembled into 32-bit
// words on a debug port.
//
// Optional build macro: SRAM16_STATS_EN
//   When defined, the module adds saturating 16-bit counters of accepted
//   reads (rd_count_o) and accepted writes (wr_count_o).
//
// Parameters
//   ADDR_W   byte address width
//   DEPTH_W  log2 of the number of half-words; index is adr_i[DEPTH_W:1]
//   READ_LAT read latency in clock edges after the sample edge (1..4)
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       asynchronous active-high reset
//   adr_i         byte address (bit 0 ignored)
//   wdata_i       write data
//   we_en_i       write enable
//   re_en_i       read enable
//   ce_n_i        chip enable, active low
//   ub_n_i        upper byte lane [15:8] enable, active low
//   lb_n_i        lower byte lane [7:0] enable, active low
//   rdata_o       read data (holds its value between responses)
//   rd_valid_o    one-cycle pulse per read response
//   word_out_o    last assembled word {hi, lo}
//   word_adr_o    base byte address of word_out_o
//   word_valid_o  one-cycle pulse when word_out_o updates
//   pair_err_o    one-cycle pulse when a held upper half is discarded
//   proto_err_o   sticky: both enables seen together with ce_n_i low
//   rd_count_o    (SRAM16_STATS_EN) accepted reads, saturating
//   wr_count_o    (SRAM16_STATS_EN) accepted writes, saturating
// ---------------------------------------------------------------------------
module sram16_responder #(
    parameter int ADDR_W   = 20,
    parameter int DEPTH_W  = 12,
    parameter int READ_LAT = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [15:0]       wdata_i,
    input  logic              we_en_i,
    input  logic              re_en_i,
    input  logic              ce_n_i,
    input  logic              ub_n_i,
    input  logic              lb_n_i,
    output logic [15:0]       rdata_o,
    output logic              rd_valid_o,
    output logic [31:0]       word_out_o,
    output logic [ADDR_W-1:0] word_adr_o,
    output logic              word_valid_o,
    output logic              pair_err_o,
`ifdef SRAM16_STATS_EN
    output logic [15:0]       rd_count_o,
    output logic [15:0]       wr_count_o,
`endif
    output logic              proto_err_o
);

    localparam int DEPTH = 1 << DEPTH_W;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic               sel;
    logic               wr_acc;
    logic               rd_acc;
    logic               proto_hit;
    logic [DEPTH_W-1:0] idx;
    logic               unused_adr_bit0;

    assign sel       = ~ce_n_i;
    assign wr_acc    = sel & we_en_i & ~re_en_i;
    assign rd_acc    = sel & re_en_i & ~we_en_i;
    assign proto_hit = sel & we_en_i & re_en_i;
    assign idx       = adr_i[DEPTH_W:1];
    // Bit 0 selects a byte within the half-word and has no meaning here.
    assign unused_adr_bit0 = adr_i[0];

    // -----------------------------------------------------------------------
    // Storage: one array per byte lane, so each lane has its own write
    // enable. The read register is loaded only on an accepted read. It has
    // no reset, which keeps it a plain block-RAM output register. A read and
    // a write can never be accepted on the same edge, because both enables
    // together is a protocol error that performs no access.
    // -----------------------------------------------------------------------
    logic [7:0] mem_hi [0:DEPTH-1];
    logic [7:0] mem_lo [0:DEPTH-1];
    logic [7:0] ram_hi_q;
    logic [7:0] ram_lo_q;

    always_ff @(posedge clk_i) begin
        if (wr_acc && !ub_n_i) begin
            mem_hi[idx] <= wdata_i[15:8];
        end
        if (wr_acc && !lb_n_i) begin
            mem_lo[idx] <= wdata_i[7:0];
        end
        if (rd_acc) begin
            ram_hi_q <= mem_hi[idx];
            ram_lo_q <= mem_lo[idx];
        end
    end

    // Stage 0 bookkeeping that travels alongside the RAM output register.
    // Lane masks are carried here and applied when the data enters stage 1.
    logic       rd_v0_q;
    logic [1:0] lane_en0_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_v0_q    <= 1'b0;
            lane_en0_q <= 2'b00;
        end else begin
            rd_v0_q <= rd_acc;
            if (rd_acc) begin
                lane_en0_q <= {~ub_n_i, ~lb_n_i};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline, stages 1..READ_LAT. A stage only loads data when its
    // input is valid, so the last stage naturally holds rdata between
    // responses. Every valid bit is reset, which drops in-flight reads.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi <= READ_LAT; gi++) begin : g_stage
            logic [15:0] in_data;
            logic        in_valid;
            logic [15:0] data_q;
            logic        valid_q;

            if (gi == 1) begin : g_first
                assign in_data  = {ram_hi_q & {8{lane_en0_q[1]}},
                                   ram_lo_q & {8{lane_en0_q[0]}}};
                assign in_valid = rd_v0_q;
            end else begin : g_next
                assign in_data  = g_stage[gi-1].data_q;
                assign in_valid = g_stage[gi-1].valid_q;
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    data_q  <= 16'h0000;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        data_q <= in_data;
                    end
                end
            end
        end
    endgenerate

    assign rdata_o    = g_stage[READ_LAT].data_q;
    assign rd_valid_o = g_stage[READ_LAT].valid_q;

    // -----------------------------------------------------------------------
    // Protocol error flag: sticky until reset.
    // -----------------------------------------------------------------------
    logic proto_err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            proto_err_q <= 1'b0;
        end else if (proto_hit) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err_o = proto_err_q;

    // -----------------------------------------------------------------------
    // Pair assembler. It looks only at accepted writes and always uses the
    // full wdata, whatever the lane enables are.
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        hi_q, hi_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [31:0]        word_out_q, word_out_d;
    logic [ADDR_W-1:0]  word_adr_q, word_adr_d;
    logic               word_valid_q, word_valid_d;
    logic               pair_err_q, pair_err_d;

    logic [ADDR_W-1:0]  wr_base;
    logic [ADDR_W-1:0]  pair_adr;
    logic               pair_match;

    assign wr_base    = {adr_i[ADDR_W-1:1], 1'b0};
    // The sum wraps modulo 2^ADDR_W because of the result width.
    assign pair_adr   = base_q + ADDR_W'(2);
    assign pair_match = (wr_base == pair_adr);

    // State register and datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            hi_q         <= 16'h0000;
            base_q       <= '0;
            word_out_q   <= 32'h0000_0000;
            word_adr_q   <= '0;
            word_valid_q <= 1'b0;
            pair_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            base_q       <= base_d;
            word_out_q   <= word_out_d;
            word_adr_q   <= word_adr_d;
            word_valid_q <= word_valid_d;
            pair_err_q   <= pair_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (wr_acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (!adr_i[1]) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A mismatching write that is itself an upper half
                    // replaces the held one and keeps waiting.
                    if (pair_match) begin
                        state_d = ST_IDLE;
                    end else if (!adr_i[1]) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        hi_d         = hi_q;
        base_d       = base_q;
        word_out_d   = word_out_q;
        word_adr_d   = word_adr_q;
        word_valid_d = 1'b0;
        pair_err_d   = 1'b0;
        if (wr_acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (!adr_i[1]) begin
                        hi_d   = wdata_i;
                        base_d = wr_base;
                    end
                end
                ST_HOLD: begin
                    if (pair_match) begin
                        word_out_d   = {hi_q, wdata_i};
                        word_adr_d   = base_q;
                        word_valid_d = 1'b1;
                    end else begin
                        pair_err_d = 1'b1;
                        if (!adr_i[1]) begin
                            hi_d   = wdata_i;
                            base_d = wr_base;
                        end
                    end
                end
                default: begin
                    hi_d = hi_q;
                end
            endcase
        end
    end

    assign word_out_o   = word_out_q;
    assign word_adr_o   = word_adr_q;
    assign word_valid_o = word_valid_q;
    assign pair_err_o   = pair_err_q;

`ifdef SRAM16_STATS_EN
    // -----------------------------------------------------------------------
    // Access statistics, saturating so a long run never wraps to a small
    // count.
    // -----------------------------------------------------------------------
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else begin
            if (rd_acc && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'h0001;
            end
            if (wr_acc && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'h0001;
            end
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
`endif

endmodule

// File: tb/tb_sram16_responder.sv
// ---------------------------------------------------------------------------
// tb_sram16_responder
//
// Self-checking bench for sram16_responder. Each read pushes its expected
// data and due cycle onto a scoreboard queue. A negedge monitor pops and
// compares every rd_valid response. Write-side outputs are checked inline by
// the scenario tasks.
// ---------------------------------------------------------------------------
module tb_sram16_responder;

    localparam int AW  = 20;
    localparam int DW  = 12;
    localparam int LAT = 2;

    logic          clk;
    logic          reset;
    logic [AW-1:0] adr;
    logic [15:0]   wdata;
    logic          we_en;
    logic          re_en;
    logic          ce_n;
    logic          ub_n;
    logic          lb_n;
    logic [15:0]   rdata;
    logic          rd_valid;
    logic [31:0]   word_out;
    logic [AW-1:0] word_adr;
    logic          word_valid;
    logic          pair_err;
    logic          proto_err;
`ifdef SRAM16_STATS_EN
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
`endif

    sram16_responder #(
        .ADDR_W   (AW),
        .DEPTH_W  (DW),
        .READ_LAT (LAT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .adr_i        (adr),
        .wdata_i      (wdata),
        .we_en_i      (we_en),
        .re_en_i      (re_en),
        .ce_n_i       (ce_n),
        .ub_n_i       (ub_n),
        .lb_n_i       (lb_n),
        .rdata_o      (rdata),
        .rd_valid_o   (rd_valid),
        .word_out_o   (word_out),
        .word_adr_o   (word_adr),
        .word_valid_o (word_valid),
        .pair_err_o   (pair_err),
`ifdef SRAM16_STATS_EN
        .rd_count_o   (rd_count),
        .wr_count_o   (wr_count),
`endif
        .proto_err_o  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory, split into byte lanes like the bus.
    logic [7:0] model_hi [0:(1<<DW)-1];
    logic [7:0] model_lo [0:(1<<DW)-1];

    typedef struct {
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t mon_e;

    // Response monitor: every rd_valid must match the oldest expected read,
    // both in data and in arrival cycle.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=1 rdata=%h at cycle %0d, required no response",
                         rdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (rdata !== mon_e.data || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL rd_response: rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                             rdata, cyc, mon_e.data, mon_e.due);
                end else begin
                    $display("read  rdata=%h cycle=%0d ok", rdata, cyc);
                end
            end
        end
    end

    // Drives one bus request for one sample edge, then returns the bus to
    // idle at edge+1. Back-to-back calls keep the request continuous.
    task automatic drive(input logic we, input logic re, input logic [AW-1:0] a,
                         input logic [15:0] d, input logic ub, input logic lb);
        rd_exp_t     e;
        logic [11:0] i;
        i     = a[DW:1];
        ce_n  = 1'b0;
        we_en = we;
        re_en = re;
        adr   = a;
        wdata = d;
        ub_n  = ub;
        lb_n  = lb;
        if (re && !we) begin
            e.data = {ub ? 8'h00 : model_hi[i], lb ? 8'h00 : model_lo[i]};
            e.due  = cyc + LAT + 1;
            exp_q.push_back(e);
        end
        if (we && !re) begin
            if (!ub) model_hi[i] = d[15:8];
            if (!lb) model_lo[i] = d[7:0];
        end
        @(posedge clk);
        #1;
        ce_n  = 1'b1;
        we_en = 1'b0;
        re_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_timeout: %0d reads outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rdata !== 16'h0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: rdata=%h rd_valid=%b, required 0000 0", rdata, rd_valid);
        end
        checks++;
        if (word_out !== 32'h0 || word_adr !== '0 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_word: word_out=%h word_adr=%h word_valid=%b, required 0",
                     word_out, word_adr, word_valid);
        end
        checks++;
        if (pair_err !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: pair_err=%b proto_err=%b, required 0 0", pair_err, proto_err);
        end
        idle_cycles(2);
        reset = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b0, 20'h00010, 16'hBEEF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00010, 16'h0000, 1'b0, 1'b0);
        // One edge after the sample edge the response must not be out yet.
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_early: rd_valid=%b one edge after sample, required 0", rd_valid);
        end
        wait_drain();
    endtask

    task automatic test_pair();
        drive(1'b1, 1'b0, 20'h00100, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 20'h00102, 16'h5678, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h12345678 || word_adr !== 20'h00100) begin
            errors++;
            $display("FAIL pair_word: valid=%b word=%h adr=%h, required 1 12345678 00100",
                     word_valid, word_out, word_adr);
        end else begin
            $display("pair  word=%h adr=%h ok", word_out, word_adr);
        end
        idle_cycles(1);
        checks++;
        if (word_valid !== 1'b0 || word_out !== 32'h12345678) begin
            errors++;
            $display("FAIL pair_pulse: valid=%b word=%h, required 0 12345678", word_valid, word_out);
        end
    endtask

    task automatic test_pair_err();
        drive(1'b1, 1'b0, 20'h00200, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 20'h00300, 16'hCCCC, 1'b0, 1'b0);
        checks++;
        if (pair_err !== 1'b1 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair_err_pulse: pair_err=%b word_valid=%b, required 1 0", pair_err, word_valid);
        end
        drive(1'b1, 1'b0, 20'h00302, 16'h5555, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'hCCCC5555 || word_adr !== 20'h00300
            || pair_err !== 1'b0) begin
            errors++;
            $display("FAIL pair_err_rehold: valid=%b word=%h adr=%h perr=%b, required 1 cccc5555 00300 0",
                     word_valid, word_out, word_adr, pair_err);
        end else begin
            $display("pair  word=%h adr=%h after discard ok", word_out, word_adr);
        end
    endtask

    task automatic test_pair_top();
        // Highest aligned base in the address space; lanes disabled to show
        // the assembler ignores them.
        drive(1'b1, 1'b0, 20'hFFFFC, 16'h0BAD, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 20'hFFFFF, 16'hF00D, 1'b1, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h0BADF00D || word_adr !== 20'hFFFFC) begin
            errors++;
            $display("FAIL pair_top: valid=%b word=%h adr=%h, required 1 0badf00d ffffc",
                     word_valid, word_out, word_adr);
        end
    endtask

    task automatic test_odd_idle();
        drive(1'b1, 1'b0, 20'h000A2, 16'h7777, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || pair_err !== 1'b0) begin
            errors++;
            $display("FAIL odd_idle: word_valid=%b pair_err=%b, required 0 0", word_valid, pair_err);
        end
        drive(1'b1, 1'b0, 20'h000A0, 16'h1111, 1'b0, 1'b0);
        checks++;
        if (pair_err !== 1'b0) begin
            errors++;
            $display("FAIL odd_idle_hold: pair_err=%b, required 0", pair_err);
        end
        drive(1'b1, 1'b0, 20'h000A3, 16'h2222, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h11112222 || word_adr !== 20'h000A0) begin
            errors++;
            $display("FAIL odd_idle_pair: valid=%b word=%h adr=%h, required 1 11112222 000a0",
                     word_valid, word_out, word_adr);
        end
    endtask

    task automatic test_lanes();
        drive(1'b1, 1'b0, 20'h00020, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 20'h00020, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 20'h00020, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00020, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 20'h00021, 16'h0000, 1'b1, 1'b0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 20'h00040, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 20'h00042, 16'h2222, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 20'h00044, 16'h3333, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 20'h00046, 16'h4444, 1'b0, 1'b0);
        // Read straight after a write to the same half-word.
        drive(1'b1, 1'b0, 20'h00048, 16'h9A9A, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00048, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00046, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00040, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00044, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00042, 16'h0000, 1'b0, 1'b0);
        wait_drain();
    endtask

    task automatic test_reset_inflight();
        drive(1'b0, 1'b1, 20'h00040, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00010, 16'h0000, 1'b0, 1'b0);
        // Third cycle: the request is still on the bus while reset hits.
        ce_n  = 1'b0;
        re_en = 1'b1;
        adr   = 20'h00044;
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (rdata !== 16'h0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_rd: rdata=%h rd_valid=%b, required 0000 0", rdata, rd_valid);
        end
        checks++;
        if (word_out !== 32'h0 || word_adr !== '0) begin
            errors++;
            $display("FAIL inflight_word: word_out=%h word_adr=%h, required 0", word_out, word_adr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        ce_n  = 1'b1;
        re_en = 1'b0;
        // Fourth read after reset: contents must have survived.
        drive(1'b0, 1'b1, 20'h00010, 16'h0000, 1'b0, 1'b0);
        idle_cycles(4);
        wait_drain();
    endtask

    task automatic test_proto();
        drive(1'b1, 1'b1, 20'h00010, 16'h0000, 1'b0, 1'b0);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_set: proto_err=%b, required 1", proto_err);
        end
        idle_cycles(3);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky: proto_err=%b, required 1", proto_err);
        end
        // The protocol-error cycle must not have written anything.
        drive(1'b0, 1'b1, 20'h00010, 16'h0000, 1'b0, 1'b0);
        wait_drain();
        reset = 1'b1;
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clear: proto_err=%b, required 0", proto_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ce_n  = 1'b1;
        we_en = 1'b0;
        re_en = 1'b0;
        ub_n  = 1'b1;
        lb_n  = 1'b1;
        adr   = '0;
        wdata = 16'h0;
        test_reset();
        test_write_read();
        test_pair();
        test_pair_err();
        test_pair_top();
        test_odd_idle();
        test_lanes();
        test_back_to_back();
        test_reset_inflight();
        test_proto();
        idle_cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram16_responder.md
Name: sram16_responder

Overview:
- Clocked responder for the CPU's external 16-bit half-word memory bus (20-bit byte address, 16-bit data, write/read enables, active-low CE/UB/LB).
- Stores half-words in an internal array and returns read data with a fixed pipelined latency.
- Reassembles consecutive half-word writes (upper half at base, lower half at base+2) into 32-bit words on a debug port, undoing the bus-side 32-to-16 split.
- Used as the memory end of the bus in system benches and as on-chip backing store.

Parameters:
- ADDR_W, 20: byte address width of adr.
- DEPTH_W, 12: log2 of implemented half-word count; the array index is adr[DEPTH_W:1], and higher address bits alias.
- READ_LAT, 2: read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- adr  in  ADDR_W  byte address; bit 0 is ignored.
- wdata  in  16  write data.
- we_en  in  1  write enable, active high.
- re_en  in  1  read enable, active high.
- ce_n  in  1  chip enable, active low.
- ub_n  in  1  upper byte lane [15:8] enable, active low.
- lb_n  in  1  lower byte lane [7:0] enable, active low.
- rdata  out  16  read data.
- rd_valid  out  1  rdata valid, one-cycle pulse per read.
- word_out  out  32  last assembled word {hi, lo}.
- word_adr  out  ADDR_W  base byte address of word_out.
- word_valid  out  1  one-cycle pulse when word_out updates.
- pair_err  out  1  one-cycle pulse when a held upper half is discarded.
- proto_err  out  1  sticky flag; set when we_en and re_en are high together with ce_n low.

Behaviour:
- Reset: all outputs go to 0 immediately. The read pipeline and assembler state are cleared and proto_err is cleared. Array contents are not cleared. A read in flight when reset asserts is dropped and produces no rd_valid.
- Sampling: each rising edge samples the request when ce_n=0. If ce_n=1, nothing happens.
- Write (we_en=1, re_en=0): one-cycle write. wdata[15:8] is written only if ub_n=0; wdata[7:0] only if lb_n=0. No response pulse.
- Read (re_en=1, we_en=0): array word, lane masks and a valid bit enter a READ_LAT-deep shift pipeline. Exactly READ_LAT edges later, rdata shows the data and rd_valid=1 for one cycle.
  - Disabled lanes read as 0.
  - Back-to-back reads are accepted every cycle; responses keep request order.
  - rdata holds its last value when rd_valid=0.
- Read after write to the same address: the read returns the data as of its sample edge. A write sampled on the same edge as an earlier read's later pipeline stage does not change that read's data.
- Both enables high with ce_n=0: no access is performed and proto_err is set (sticky until reset).
- Pair assembler (tracks writes only; reads do not affect it). States:
  - IDLE:
    - A write with adr[1]=0 latches hi=wdata and base=adr with bit 0 cleared, then goes to HOLD.
    - A write with adr[1]=1 stays in IDLE with no pulse.
  - HOLD:
    - A write with adr = base+2 (bit 0 ignored) sets word_out={hi, wdata}, word_adr=base and word_valid=1 for one cycle, then goes to IDLE.
    - Any other write pulses pair_err=1 and discards hi. If that write has adr[1]=0 it becomes the new hi (stay in HOLD); otherwise go to IDLE.
  - The assembler always uses the full wdata, ignoring lane enables.
- Width: base+2 is computed modulo 2^ADDR_W, so the top address wraps to 0.

Optional Feature:
- Macro: SRAM16_STATS_EN.
- When defined:
  - Extra outputs rd_count[15:0] and wr_count[15:0].
  - Each counts accepted reads/writes, saturating at 16'hFFFF.
  - Both clear on reset.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Write 16'hBEEF at adr 20'h00010 (ub_n=lb_n=0), then read it -> rdata=16'hBEEF with rd_valid exactly 2 cycles after the read edge.
- Write 16'h1234 at 20'h00100, then 16'h5678 at 20'h00102 -> word_valid pulse with word_out=32'h12345678, word_adr=20'h00100.
- Write 16'hAAAA at 20'h00200, then a write at 20'h00300 -> pair_err pulse, no word_valid, new hold base 20'h00300.
- Fill 16'hFFFF at 20'h00020, then write 16'h0000 with ub_n=1, lb_n=0 -> read returns 16'hFF00. A read with lb_n=1 returns 16'hFF00 & 16'hFF00 = 16'hFF00 with the low byte forced to 0.
- Issue reads every cycle for 4 cycles, assert reset in the 3rd cycle -> outputs 0 at once, no rd_valid for dropped reads. Asserting we_en and re_en together afterwards sets proto_err=1 until reset.
